// File: rtl/hamming_scrubber.sv
// Background SEC scrubber: walks the register file, corrects single-bit Hamming errors
// and flags uncorrectable syndromes. Define SCRUB_CONTINUOUS_EN for back-to-back passes.
module hamming_scrubber #(
    parameter int NREGS = 32,
    parameter int CW_W  = 38
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [4:0]      rf_rd_addr,
    input  logic [CW_W-1:0] rf_rd_data,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [CW_W-1:0] rf_wr_data,
    input  logic            cpu_wr_en,
    input  logic [4:0]      cpu_wr_addr,
    output logic            busy,
    output logic            done,
    output logic [7:0]      corr_cnt,
    output logic            uncorr_flag,
    output logic [4:0]      uncorr_addr
);

    typedef enum logic [1:0] {IDLE, RD, CK, WB} state_t;

    localparam logic [4:0] LAST_ADDR = 5'(NREGS - 1);
    localparam logic [5:0] MAX_SYN   = 6'(CW_W);

    state_t          state, state_nx;
    logic [4:0]      addr, addr_nx;
    logic [CW_W-1:0] wr_data_nx;
    logic            done_nx, corr_inc, uncorr_set, advance;
    logic [5:0]      syndrome;
    logic            cpu_hit;

    // Register-file protocol: read data returns one cycle after rf_rd_addr; a write
    // happens on any edge where rf_wr_en is high. The CPU port always wins, so the
    // scrubber never strobes rf_wr_en while cpu_wr_en is high.
    assign rf_rd_addr = addr;
    assign rf_wr_addr = addr;
    assign rf_wr_en   = (state == WB) && !cpu_wr_en;
    assign busy       = (state != IDLE);
    assign cpu_hit    = cpu_wr_en && (cpu_wr_addr == addr);

    always_comb begin
        syndrome = '0;
        for (int p = 1; p <= CW_W; p++) begin
            if (rf_rd_data[p-1]) syndrome = syndrome ^ 6'(p);
        end
    end

    always_comb begin
        state_nx   = state;
        addr_nx    = addr;
        wr_data_nx = rf_wr_data;
        done_nx    = 1'b0;
        corr_inc   = 1'b0;
        uncorr_set = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
`ifdef SCRUB_CONTINUOUS_EN
                state_nx = RD;
                addr_nx  = '0;
`else
                // A start coinciding with the done pulse belongs to the finished pass.
                if (start && !done) begin
                    state_nx = RD;
                    addr_nx  = '0;
                end
`endif
            end
            RD: begin
                if (!cpu_wr_en) state_nx = CK;
            end
            CK: begin
                if (syndrome == '0) begin
                    advance = 1'b1;
                end else if (syndrome <= MAX_SYN) begin
                    // A CPU write to this word makes our copy stale: drop it.
                    if (cpu_hit) begin
                        advance = 1'b1;
                    end else begin
                        wr_data_nx = rf_rd_data ^ ({{(CW_W-1){1'b0}}, 1'b1} << (syndrome - 6'd1));
                        state_nx   = WB;
                    end
                end else begin
                    uncorr_set = 1'b1;
                    advance    = 1'b1;
                end
            end
            WB: begin
                if (!cpu_wr_en || cpu_hit) begin
                    advance  = 1'b1;
                    corr_inc = !cpu_wr_en;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (advance) begin
            if (addr == LAST_ADDR) begin
                done_nx = 1'b1;
                addr_nx = '0;
`ifdef SCRUB_CONTINUOUS_EN
                state_nx = RD;
`else
                state_nx = IDLE;
`endif
            end else begin
                addr_nx  = addr + 5'd1;
                state_nx = RD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            rf_wr_data  <= '0;
            done        <= 1'b0;
            corr_cnt    <= '0;
            uncorr_flag <= 1'b0;
            uncorr_addr <= '0;
        end else begin
            state      <= state_nx;
            addr       <= addr_nx;
            rf_wr_data <= wr_data_nx;
            done       <= done_nx;
            if (corr_inc && (corr_cnt != 8'hFF)) corr_cnt <= corr_cnt + 8'd1;
            if (uncorr_set) begin
                uncorr_flag <= 1'b1;
                if (!uncorr_flag) uncorr_addr <= addr;
            end
        end
    end

endmodule

// File: tb/tb_hamming_scrubber.sv
// Directed and randomized bench for hamming_scrubber with a behavioural register file
// and an expected-write scoreboard derived from the Hamming syndrome rules.
module tb_hamming_scrubber;

    localparam int CW = 38;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst, start, cpu_wr_en;
    logic [4:0]    cpu_wr_addr, rf_rd_addr, rf_wr_addr, uncorr_addr;
    logic [CW-1:0] rf_rd_data, rf_wr_data;
    logic          rf_wr_en, busy, done, uncorr_flag;
    logic [7:0]    corr_cnt;

    logic [CW-1:0] mem [NR];
    logic [CW-1:0] rd_q;
    logic [CW+4:0] exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int m_corr   = 0;
    bit m_flag   = 1'b0;
    int m_uaddr  = 0;

    hamming_scrubber dut (
        .clk(clk), .rst(rst), .start(start),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr),
        .busy(busy), .done(done), .corr_cnt(corr_cnt),
        .uncorr_flag(uncorr_flag), .uncorr_addr(uncorr_addr)
    );

    always #5 clk = ~clk;

    // Register file read port: one-cycle latency.
    always @(posedge clk) rd_q <= mem[rf_rd_addr];
    assign rf_rd_data = rd_q;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Syndrome bit b is the parity of every codeword position whose index has bit b set.
    function automatic logic [5:0] syn(input logic [CW-1:0] cw);
        logic [5:0] s;
        for (int b = 0; b < 6; b++) begin
            int ones = 0;
            for (int p = 1; p <= CW; p++) if (((p >> b) & 1) == 1 && cw[p-1]) ones++;
            s[b] = ones[0];
        end
        return s;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [31:0] data);
        logic [CW-1:0] cw = '0;
        logic [5:0]    s;
        int            j = 0;
        for (int p = 1; p <= CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = data[j];
                j++;
            end
        end
        s = syn(cw);
        for (int b = 0; b < 6; b++) cw[(1 << b) - 1] = s[b];
        return cw;
    endfunction

    function automatic logic [CW-1:0] flip(input logic [CW-1:0] cw, input int pos);
        logic [CW-1:0] one = 1;
        return cw ^ (one << pos);
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < NR; a++) mem[a] = '0;
    endtask

    // Expected outcome of an undisturbed pass over the current memory image.
    task automatic model_pass(output int lat);
        int writes = 0;
        for (int a = 0; a < NR; a++) begin
            logic [5:0] s = syn(mem[a]);
            if (s == 0) begin
            end else if (int'(s) <= CW) begin
                exp_q.push_back({5'(a), flip(mem[a], int'(s) - 1)});
                writes++;
                if (m_corr < 255) m_corr++;
            end else if (!m_flag) begin
                m_flag  = 1'b1;
                m_uaddr = a;
            end
        end
        lat = 2 * NR + writes;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wr_en"}, rf_wr_en, 0);
        check({tag, "_rd_addr"}, rf_rd_addr, 0);
        check({tag, "_wr_addr"}, rf_wr_addr, 0);
        check({tag, "_wr_data"}, rf_wr_data, 0);
        check({tag, "_corr_cnt"}, corr_cnt, 0);
        check({tag, "_uncorr_flag"}, uncorr_flag, 0);
        check({tag, "_uncorr_addr"}, uncorr_addr, 0);
    endtask

    task automatic model_reset();
        m_corr  = 0;
        m_flag  = 1'b0;
        m_uaddr = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_corr_cnt"}, corr_cnt, m_corr);
        check({tag, "_uncorr_flag"}, uncorr_flag, m_flag);
        if (m_flag) check({tag, "_uncorr_addr"}, uncorr_addr, m_uaddr);
    endtask

    // Cycle k is the clock period following the k-th edge after the one sampling start.
    task automatic run_pass(input int cpu_lo, input int cpu_hi, input logic [4:0] cpu_a,
                            input int rst_at, input int exp_lat, input bit chk_rd0);
        bit seen = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        cpu_wr_en = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start       = (k == 20);
            cpu_wr_en   = (k >= cpu_lo) && (k <= cpu_hi);
            cpu_wr_addr = cpu_a;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check_reset_vals("mid_pass_rst");
                @(negedge clk);
                rst       = 1'b0;
                cpu_wr_en = 1'b0;
                start     = 1'b0;
                model_reset();
                return;
            end
            #1;
            if (k == 30) check("busy_mid_pass", busy, 1);
            if (chk_rd0 && cpu_wr_en) check("rd_addr_stall", rf_rd_addr, 0);
            if (cpu_wr_en) check("no_wr_during_cpu", rf_wr_en, 0);
            if (rf_wr_en) begin
                if (exp_q.size() == 0) check("unexpected_wr", rf_wr_en, 0);
                else check("wr_word", {rf_wr_addr, rf_wr_data}, exp_q.pop_front());
            end
            if (done) begin
                seen = 1'b1;
                check("done_latency", k, exp_lat);
                break;
            end
        end
        if (!seen) check("done_timeout", seen, 1);
        cpu_wr_en = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("exp_q_drained", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; cpu_wr_en = 1'b0; cpu_wr_addr = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;

        // Clean pass of all-zero codewords.
        model_pass(lat);
        run_pass(-1, -2, 5'd0, -1, lat, 1'b0);
        check_status("clean");

        // Single-bit error at addr 3, bit 5.
        mem[3] = flip('0, 5);
        model_pass(lat);
        run_pass(-1, -2, 5'd0, -1, lat, 1'b0);
        check_status("single");

        // Uncorrectable at addr 7, then a later one at addr 9 must not move uncorr_addr.
        clear_mem();
        mem[7] = flip(flip('0, 30), 31);
        model_pass(lat);
        run_pass(-1, -2, 5'd0, -1, lat, 1'b0);
        check_status("uncorr");
        check("uncorr_addr_7", uncorr_addr, 7);
        clear_mem();
        mem[9] = flip(flip('0, 30), 31);
        model_pass(lat);
        run_pass(-1, -2, 5'd0, -1, lat, 1'b0);
        check_status("uncorr_first");

        // CPU write to the word under check: stale, no write-back or count.
        do_reset();
        clear_mem();
        mem[3] = flip('0, 5);
        run_pass(7, 7, 5'd3, -1, 2 * NR, 1'b0);
        check_status("stale");

        // CPU holds the port for 10 cycles while addr 0 is being read.
        clear_mem();
        model_pass(lat);
        run_pass(0, 9, 5'd5, -1, lat + 10, 1'b1);
        check_status("rd_stall");

        // Write-back stalled 3 cycles by CPU writes elsewhere.
        mem[3] = flip('0, 12);
        model_pass(lat);
        run_pass(8, 10, 5'd9, -1, lat + 3, 1'b0);
        check_status("wb_stall");

        // CPU writes the same word during write-back: abandoned.
        mem[3] = flip('0, 20);
        run_pass(8, 8, 5'd3, -1, 2 * NR + 1, 1'b0);
        check_status("wb_abandon");

        // Randomized passes: clean, single and double errors.
        do_reset();
        for (int pass = 0; pass < 8; pass++) begin
            for (int a = 0; a < NR; a++) begin
                int r  = $urandom_range(0, 9);
                int p1 = $urandom_range(0, CW - 1);
                int p2 = (p1 + $urandom_range(1, CW - 1)) % CW;
                mem[a] = encode($urandom());
                if (r >= 6 && r <= 8) mem[a] = flip(mem[a], p1);
                if (r == 9) mem[a] = flip(flip(mem[a], p1), p2);
            end
            model_pass(lat);
            run_pass(-1, -2, 5'd0, -1, lat, 1'b0);
            check_status("random");
        end

        // Saturation of corr_cnt: 9 passes of 32 corrections.
        do_reset();
        for (int pass = 0; pass < 9; pass++) begin
            for (int a = 0; a < NR; a++) mem[a] = flip(encode($urandom()), $urandom_range(0, CW - 1));
            model_pass(lat);
            run_pass(-1, -2, 5'd0, -1, lat, 1'b0);
        end
        check("corr_cnt_saturated", corr_cnt, 255);

        // Reset during write-back of addr 3: no write may follow release.
        clear_mem();
        mem[3] = flip('0, 5);
        run_pass(-1, -2, 5'd0, 8, -1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            check("no_wr_after_rst", rf_wr_en, 0);
        end
        check_reset_vals("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
